// File: rtl/mem_responder.sv
// Wait-stated single-port word memory that answers an LC-3 style MAR/MDR request handshake.
// One access at a time: IDLE latches the request, BUSY counts wait states, RESP strobes ready.
module mem_responder #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    output logic        busy,
    output logic        proto_err,
    output logic        abort
);

    localparam int unsigned CntW  = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int unsigned Depth = 1 << ADDR_BITS;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [15:0] mem_q [Depth];

    logic [1:0]           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [15:0]          wdata_q, wdata_d;
    logic                 is_wr_q, is_wr_d;
    logic                 err_seen_q, err_seen_d;
    logic [15:0]          rdata_q, rdata_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 perr_q, perr_d;
    logic                 abort_q, abort_d;

    logic                 req;
    logic                 complete;
    logic [ADDR_BITS-1:0] acc_addr;
    logic [15:0]          acc_wdata;
    logic                 acc_wr;

    assign req = mem_we | mem_re;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_wr_d    = is_wr_q;
        err_seen_d = err_seen_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        perr_d     = 1'b0;
        abort_d    = 1'b0;
        complete   = 1'b0;
        acc_addr   = addr_q;
        acc_wdata  = wdata_q;
        acc_wr     = is_wr_q;

        case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d     = mem_addr[ADDR_BITS-1:0];
                    wdata_d    = mem_wdata;
                    is_wr_d    = mem_we;
                    err_seen_d = mem_we & mem_re;
                    perr_d     = mem_we & mem_re;
                    // With zero wait states the access completes straight from the inputs.
                    acc_addr   = mem_addr[ADDR_BITS-1:0];
                    acc_wdata  = mem_wdata;
                    acc_wr     = mem_we;
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                        state_d  = StResp;
                    end else begin
                        cnt_d   = CntW'(WAIT_CYCLES);
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (!req) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    if (!err_seen_q && (is_wr_q ? (mem_re && !mem_we) : mem_we)) begin
                        perr_d     = 1'b1;
                        err_seen_d = 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (cnt_q <= CntW'(1)) begin
                        complete = 1'b1;
                        state_d  = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (complete) begin
            ready_d = 1'b1;
            if (!acc_wr) begin
                rdata_d = mem_q[acc_addr];
            end
        end

        busy_d = (state_d == StBusy) || (state_d == StResp);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            err_seen_q <= 1'b0;
            rdata_q    <= 16'h0000;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            perr_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_wr_q    <= is_wr_d;
            err_seen_q <= err_seen_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            perr_q     <= perr_d;
            abort_q    <= abort_d;
        end
    end

    // Array is deliberately not reset; rst_n only gates the write so a cancelled access is lost.
    always_ff @(posedge clk) begin
        if (rst_n && complete && acc_wr) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    if (ADDR_BITS < 16) begin : g_unused_addr
        logic unused_addr_hi;
        assign unused_addr_hi = ^mem_addr[15:ADDR_BITS];
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign busy      = busy_q;
    assign proto_err = perr_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (4 wait states and 0 wait states) checked every cycle
// against a transaction-level model, plus directed literal scenarios.
module tb_mem_responder;

    localparam int unsigned AB = 8;
    localparam int DEPTH = 1 << AB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        we    [2];
    logic        re    [2];
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic [15:0] rdata [2];
    logic        rdy   [2];
    logic        bsy   [2];
    logic        perr  [2];
    logic        abrt  [2];

    mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(4)) u_w4 (
        .clk(clk), .rst_n(rst_n[0]), .mem_we(we[0]), .mem_re(re[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ready(rdy[0]), .busy(bsy[0]),
        .proto_err(perr[0]), .abort(abrt[0])
    );

    mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n[1]), .mem_we(we[1]), .mem_re(re[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ready(rdy[1]), .busy(bsy[1]),
        .proto_err(perr[1]), .abort(abrt[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    // Transaction-level model: an access started at edge s completes at edge s+W.
    bit          started  [2];
    bit          active   [2];
    bit          in_resp  [2];
    int          elapsed  [2];
    int          m_addr   [2];
    logic [15:0] m_data   [2];
    bit          m_wr     [2];
    bit          m_err    [2];
    logic [15:0] m_rdata  [2];
    bit          rd_known [2];
    logic [15:0] mem_m    [2][DEPTH];
    bit          known    [2][DEPTH];
    int          rdy_cnt  [2];
    int          perr_cnt [2];
    int          abort_cnt[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit req, fin, e_rdy, e_perr, e_abort, e_busy;
            fin = 0; e_rdy = 0; e_perr = 0; e_abort = 0;
            req = (we[i] | re[i]) === 1'b1;
            if (rst_n[i] !== 1'b1) begin
                started[i] = 1; active[i] = 0; in_resp[i] = 0;
                m_rdata[i] = 16'h0000; rd_known[i] = 1;
            end else if (in_resp[i]) begin
                in_resp[i] = 0;
            end else if (!active[i]) begin
                if (req) begin
                    m_addr[i] = int'(addr[i]) % DEPTH;
                    m_data[i] = wdata[i];
                    m_wr[i]   = we[i];
                    m_err[i]  = we[i] & re[i];
                    e_perr    = m_err[i];
                    elapsed[i] = 0;
                    if (wait_of(i) == 0) fin = 1;
                    else active[i] = 1;
                end
            end else begin
                elapsed[i]++;
                if (!req) begin
                    active[i] = 0;
                    e_abort = 1;
                end else begin
                    if (!m_err[i] && (m_wr[i] ? (re[i] && !we[i]) : we[i])) begin
                        e_perr = 1; m_err[i] = 1;
                    end
                    if (elapsed[i] == wait_of(i)) begin
                        active[i] = 0; fin = 1;
                    end
                end
            end
            if (fin) begin
                e_rdy = 1; in_resp[i] = 1;
                if (m_wr[i]) begin
                    mem_m[i][m_addr[i]] = m_data[i];
                    known[i][m_addr[i]] = 1;
                end else begin
                    m_rdata[i]  = mem_m[i][m_addr[i]];
                    rd_known[i] = known[i][m_addr[i]];
                end
            end
            e_busy = active[i] | in_resp[i];
            if (started[i]) begin
                chk($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(e_rdy));
                chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(e_busy));
                chk($sformatf("proto_err[%0d]", i), 32'(perr[i]), 32'(e_perr));
                chk($sformatf("abort[%0d]", i), 32'(abrt[i]), 32'(e_abort));
                if (rd_known[i]) chk($sformatf("rdata[%0d]", i), 32'(rdata[i]), 32'(m_rdata[i]));
                if (rdy[i] === 1'b1) rdy_cnt[i]++;
                if (perr[i] === 1'b1) perr_cnt[i]++;
                if (abrt[i] === 1'b1) abort_cnt[i]++;
            end
        end
    end

    task automatic access(input int i, input bit w, input bit r, input logic [15:0] a,
                          input logic [15:0] d, output int lat);
        @(negedge clk); #1;
        we[i] = w; re[i] = r; addr[i] = a; wdata[i] = d;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rdy[i] === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk($sformatf("ready_within_bound[%0d]", i), 32'(lat > 0), 32'd1);
        #1;
        we[i] = 0; re[i] = 0;
    endtask

    task automatic dropped(input int i, input bit w, input bit r, input logic [15:0] a,
                           input logic [15:0] d, input int hold);
        @(negedge clk); #1;
        we[i] = w; re[i] = r; addr[i] = a; wdata[i] = d;
        repeat (hold) @(negedge clk);
        #1;
        we[i] = 0; re[i] = 0;
        repeat (8) @(negedge clk);
        #1;
    endtask

    task automatic b2b();
        int gap;
        bit seen;
        int nxt;
        @(negedge clk); #1;
        we[1] = 1; re[1] = 0; addr[1] = 16'h0000; wdata[1] = 16'h1000;
        for (int s = 0; s < 8; s++) begin
            gap = 0; seen = 0;
            for (int n = 1; n <= 10 && !seen; n++) begin
                @(negedge clk);
                gap = n;
                seen = (rdy[1] === 1'b1);
            end
            chk($sformatf("b2b_gap[%0d]", s), 32'(gap), (s == 0) ? 32'd1 : 32'd2);
            if (s >= 4) chk($sformatf("b2b_rdata[%0d]", s), 32'(rdata[1]), 32'(16'h1000 + 16'(s - 4)));
            #1;
            if (s < 7) begin
                nxt = s + 1;
                we[1] = (nxt < 4); re[1] = (nxt >= 4);
                addr[1] = 16'(nxt % 4); wdata[1] = 16'h1000 + 16'(nxt);
            end else begin
                we[1] = 0; re[1] = 0;
            end
        end
    endtask

    task automatic rand_ops(input int i, input int iters);
        for (int t = 0; t < iters; t++) begin
            int kind, hold;
            bit got;
            kind = $urandom_range(0, 8);
            hold = $urandom_range(1, 6);
            got = 0;
            @(negedge clk); #1;
            addr[i]  = 16'($urandom) & 16'hFF0F;
            wdata[i] = 16'($urandom);
            if (kind <= 2) begin we[i] = 1; re[i] = 0; end
            else if (kind <= 5) begin we[i] = 0; re[i] = 1; end
            else if (kind == 6) begin we[i] = 1; re[i] = 1; end
            else if (kind == 7) begin we[i] = 1'($urandom); re[i] = !we[i]; end
            else begin we[i] = 0; re[i] = 1; end
            for (int n = 1; n <= 40; n++) begin
                @(negedge clk);
                if (rdy[i] === 1'b1) begin
                    got = 1;
                    break;
                end
                if (kind == 7 && n == hold) break;
                if (kind == 8 && n == 1) begin
                    #1; we[i] = 1; re[i] = 0;
                end
            end
            if (kind != 7) chk($sformatf("rand_ready_bound[%0d]", i), 32'(got), 32'd1);
            #1;
            we[i] = 0; re[i] = 0;
        end
    endtask

    initial begin
        int lat, snap_a, snap_r, snap_p;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 0; we[i] = 0; re[i] = 0; addr[i] = 16'h0; wdata[i] = 16'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_rdata[%0d]", i), 32'(rdata[i]), 32'h0);
            chk($sformatf("reset_ready[%0d]", i), 32'(rdy[i]), 32'h0);
            chk($sformatf("reset_busy[%0d]", i), 32'(bsy[i]), 32'h0);
        end
        #1;
        rst_n[0] = 1; rst_n[1] = 1;

        access(0, 1, 0, 16'h0010, 16'hBEEF, lat);
        chk("w4_write_latency", 32'(lat), 32'd5);
        access(0, 0, 1, 16'h0010, 16'h0000, lat);
        chk("w4_read_latency", 32'(lat), 32'd5);
        chk("w4_read_beef", 32'(rdata[0]), 32'h0000BEEF);

        access(0, 1, 0, 16'h0105, 16'h1234, lat);
        access(0, 0, 1, 16'h0005, 16'h0000, lat);
        chk("wrap_read", 32'(rdata[0]), 32'h00001234);

        access(0, 1, 0, 16'h0040, 16'h7777, lat);
        access(0, 0, 1, 16'h0010, 16'h0000, lat);
        snap_a = abort_cnt[0]; snap_r = rdy_cnt[0];
        dropped(0, 0, 1, 16'h0040, 16'h0000, 2);
        chk("abort_read_pulses", 32'(abort_cnt[0] - snap_a), 32'd1);
        chk("abort_read_no_ready", 32'(rdy_cnt[0] - snap_r), 32'd0);
        chk("abort_read_rdata_held", 32'(rdata[0]), 32'h0000BEEF);
        dropped(0, 1, 0, 16'h0040, 16'h9999, 2);
        access(0, 0, 1, 16'h0040, 16'h0000, lat);
        chk("abort_write_kept_old", 32'(rdata[0]), 32'h00007777);

        snap_p = perr_cnt[0];
        access(0, 1, 1, 16'h0020, 16'h5A5A, lat);
        chk("collision_perr_once", 32'(perr_cnt[0] - snap_p), 32'd1);
        access(0, 0, 1, 16'h0020, 16'h0000, lat);
        chk("collision_written", 32'(rdata[0]), 32'h00005A5A);

        access(0, 1, 0, 16'h0030, 16'h1111, lat);
        snap_r = rdy_cnt[0];
        @(negedge clk); #1;
        we[0] = 1; addr[0] = 16'h0030; wdata[0] = 16'hFFFF;
        repeat (2) @(negedge clk);
        #1 rst_n[0] = 0;
        @(negedge clk);
        chk("midreset_rdata", 32'(rdata[0]), 32'h0);
        chk("midreset_ready", 32'(rdy[0]), 32'h0);
        chk("midreset_busy", 32'(bsy[0]), 32'h0);
        chk("midreset_perr", 32'(perr[0]), 32'h0);
        chk("midreset_abort", 32'(abrt[0]), 32'h0);
        #1 we[0] = 0;
        @(negedge clk);
        #1 rst_n[0] = 1;
        repeat (6) @(negedge clk);
        #1;
        chk("midreset_no_ready", 32'(rdy_cnt[0] - snap_r), 32'd0);
        access(0, 0, 1, 16'h0030, 16'h0000, lat);
        chk("midreset_kept_old", 32'(rdata[0]), 32'h00001111);

        b2b();

        fork
            rand_ops(0, 150);
            rand_ops(1, 300);
        join
        repeat (4) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8, number of implemented word-address bits (array depth 2^ADDR_BITS x 16); legal range 4..16.
REQ-002 Parameter WAIT_CYCLES, default 4, wait states inserted before mem_ready; legal range 0..15.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 mem_we  input  1  write request; held by the initiator until mem_ready.
REQ-007 mem_re  input  1  read request; held by the initiator until mem_ready.
REQ-008 mem_addr  input  16  word address (MAR value).
REQ-009 mem_wdata  input  16  write data (MDR value).
REQ-010 mem_rdata  output  16  read data returned to the initiator.
REQ-011 mem_ready  output  1  one-cycle completion strobe (LC-3 R signal).
REQ-012 busy  output  1  high while an access is in progress (states BUSY and RESP).
REQ-013 proto_err  output  1  one-cycle pulse on a protocol violation.
REQ-014 abort  output  1  one-cycle pulse when a request is withdrawn before completion.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and RESP. All outputs SHALL be registered.
REQ-016 In IDLE, a sampled request (mem_we or mem_re) SHALL latch mem_addr[ADDR_BITS-1:0], mem_wdata and the access type, and SHALL load the wait counter.
REQ-017 The latched address, data and type SHALL be used for the whole access; changes on mem_addr or mem_wdata during BUSY SHALL be ignored.
REQ-018 If a request is first sampled in cycle k, mem_ready SHALL be high in cycle k+WAIT_CYCLES+1 only. With WAIT_CYCLES=0 the FSM SHALL go IDLE->RESP directly.
REQ-019 A write SHALL update the array on the edge that enters RESP; the new data SHALL be readable by any later access.
REQ-020 For a read, mem_rdata SHALL be loaded from the array on the edge that enters RESP. It SHALL then hold its value until the next read completes, including across writes.
REQ-021 RESP SHALL last exactly one cycle and then go to IDLE unconditionally. A request still high in IDLE on the following edge SHALL start a new access, so back-to-back accesses are legal.
REQ-022 If mem_we and mem_re are both high when sampled in IDLE, the access SHALL be performed as a write and proto_err SHALL pulse once.
REQ-023 If both mem_we and mem_re go low while in BUSY, the FSM SHALL return to IDLE. In that case abort SHALL pulse once, no array write SHALL occur, mem_rdata SHALL be unchanged, and mem_ready SHALL stay low.
REQ-024 A change of request type during BUSY (re->we or we->re) SHALL NOT alter the latched type and SHALL pulse proto_err once per access.
REQ-025 Addresses SHALL wrap modulo 2^ADDR_BITS: upper address bits are ignored, and 0x0100 aliases 0x0000 when ADDR_BITS=8.
REQ-026 The wait counter SHALL be ceil(log2(WAIT_CYCLES+1)) bits or wider. It SHALL decrement once per BUSY cycle and SHALL never underflow.

Reset
REQ-027 With rst_n low at a rising edge, the FSM SHALL enter IDLE, the wait counter SHALL clear, and outputs SHALL be mem_ready=0, busy=0, proto_err=0, abort=0, mem_rdata=16'h0000.
REQ-028 Reset asserted mid-access SHALL cancel the access: no array write and no mem_ready pulse.
REQ-029 Array contents SHALL NOT be cleared by reset; they SHALL survive reset.
REQ-030 Requests sampled while rst_n is low SHALL be ignored. The first access after reset SHALL start on the first edge with rst_n high and a request present.

Verification
REQ-031 WAIT_CYCLES=4: write 16'hBEEF to 16'h0010, then read 16'h0010 -> mem_ready in cycle k+5 for each access, and mem_rdata=16'hBEEF in the read's ready cycle.
REQ-032 WAIT_CYCLES=0: back-to-back writes to addresses 0..3 with data 16'h1000+i, then reads -> one ready per access every 2 cycles, and read data matches.
REQ-033 ADDR_BITS=8: write 16'h1234 to 16'h0105, then read 16'h0005 -> mem_rdata=16'h1234 (wrap-around).
REQ-034 Read request dropped 2 cycles into a 4-wait access -> abort pulses once, no mem_ready, mem_rdata unchanged. A write dropped the same way -> the array location keeps its old value.
REQ-035 mem_we=mem_re=1 at 16'h0020 with data 16'h5A5A -> proto_err pulses once, then a read of 16'h0020 returns 16'h5A5A.
REQ-036 rst_n pulled low in the wait of a write of 16'hFFFF to 16'h0030 -> outputs at reset values, no ready pulse, and the location keeps its pre-reset value.
